// File: rtl/lsu_if.sv
// Pipeline and memory-side signals of the load/store unit, grouped for port connection.
// The LSU uses the slave modport; the EXU/WBU/memory side uses the master modport.
interface lsu_if #(
  parameter int CPU_WIDTH = 32
);
  logic [CPU_WIDTH-1:0] i_exu_res;
  logic [CPU_WIDTH-1:0] i_rs2;
  logic [3:0]           i_lsu_opt;
  logic                 i_pre_valid;
  logic                 o_pre_ready;

  logic                 o_post_valid;
  logic                 i_post_ready;
  logic [CPU_WIDTH-1:0] o_lsu_res;
  logic                 o_misalign;

  logic                 o_mem_valid;
  logic                 i_mem_ready;
  logic                 o_mem_wen;
  logic [CPU_WIDTH-1:0] o_mem_addr;
  logic [CPU_WIDTH-1:0] o_mem_wdata;
  logic [3:0]           o_mem_wmask;
  logic                 i_mem_rvalid;
  logic [CPU_WIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_exu_res, i_rs2, i_lsu_opt, i_pre_valid, i_post_ready,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_pre_ready, o_post_valid, o_lsu_res, o_misalign,
    output o_mem_valid, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask
  );

  modport master (
    output i_exu_res, i_rs2, i_lsu_opt, i_pre_valid, i_post_ready,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_pre_ready, o_post_valid, o_lsu_res, o_misalign,
    input  o_mem_valid, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one EXU op at a time, issues a single word-aligned memory
// request for loads/stores, and returns an extended load result or pass-through value.
//
// state  | meaning
// IDLE   | ready for a new op from EXU
// REQ    | memory request presented, waiting for i_mem_ready
// WAIT   | request accepted, waiting for i_mem_rvalid
// RESP   | result held for WBU until i_post_ready
module lsu #(
  parameter int CPU_WIDTH = 32
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  lsu_if.slave  bus
);

  localparam logic [3:0] OP_LB  = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1001;
  localparam logic [3:0] OP_SH  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CPU_WIDTH-1:0] addr_q, addr_d;
  logic [CPU_WIDTH-1:0] rs2_q, rs2_d;
  logic [CPU_WIDTH-1:0] res_q, res_d;
  logic [3:0]           opt_q, opt_d;
  logic                 mis_q, mis_d;

  logic                 in_mem;
  logic                 in_mis;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [CPU_WIDTH-1:0] rd_res;
  logic [CPU_WIDTH-1:0] wdata;
  logic [3:0]           wmask;
  logic                 is_store;

  // Classify the op being offered; unknown codes fall through as NOP.
  always_comb begin
    in_mem = 1'b0;
    in_mis = 1'b0;
    case (bus.i_lsu_opt)
      OP_LB, OP_LBU, OP_SB: in_mem = 1'b1;
      OP_LH, OP_LHU, OP_SH: begin
        in_mem = 1'b1;
        in_mis = bus.i_exu_res[0];
      end
      OP_LW, OP_SW: begin
        in_mem = 1'b1;
        in_mis = |bus.i_exu_res[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = bus.i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = bus.i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
    rd_res   = '0;
    wdata    = '0;
    wmask    = 4'b0000;
    is_store = 1'b0;
    case (opt_q)
      OP_LB:  rd_res = {{24{byte_sel[7]}}, byte_sel};
      OP_LH:  rd_res = {{16{half_sel[15]}}, half_sel};
      OP_LW:  rd_res = bus.i_mem_rdata;
      OP_LBU: rd_res = {24'h0, byte_sel};
      OP_LHU: rd_res = {16'h0, half_sel};
      OP_SB: begin
        is_store = 1'b1;
        wdata    = {4{rs2_q[7:0]}};
        wmask    = 4'b0001 << addr_q[1:0];
      end
      OP_SH: begin
        is_store = 1'b1;
        wdata    = {2{rs2_q[15:0]}};
        wmask    = 4'b0011 << addr_q[1:0];
      end
      OP_SW: begin
        is_store = 1'b1;
        wdata    = rs2_q;
        wmask    = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rs2_d   = rs2_q;
    opt_d   = opt_q;
    res_d   = res_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_pre_valid) begin
          addr_d = bus.i_exu_res;
          rs2_d  = bus.i_rs2;
          opt_d  = bus.i_lsu_opt;
          res_d  = '0;
          mis_d  = 1'b0;
          if (!in_mem) begin
            res_d   = bus.i_exu_res;
            state_d = S_RESP;
          end else if (in_mis) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.i_mem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_mem_rvalid) begin
          res_d   = rd_res;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_post_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
      opt_q   <= 4'b0000;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rs2_q   <= rs2_d;
      res_q   <= res_d;
      opt_q   <= opt_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.o_pre_ready  = (state_q == S_IDLE);
  assign bus.o_mem_valid  = (state_q == S_REQ);
  assign bus.o_post_valid = (state_q == S_RESP);
  assign bus.o_lsu_res    = res_q;
  assign bus.o_misalign   = mis_q;
  assign bus.o_mem_wen    = is_store;
  assign bus.o_mem_addr   = {addr_q[CPU_WIDTH-1:2], 2'b00};
  assign bus.o_mem_wdata  = wdata;
  assign bus.o_mem_wmask  = wmask;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard-driven bench for lsu: expected results are queued when an op is offered
// and compared when the DUT presents its response.
module tb_lsu;
  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] LB  = 4'b0001;
  localparam logic [3:0] LH  = 4'b0010;
  localparam logic [3:0] LW  = 4'b0011;
  localparam logic [3:0] LBU = 4'b0100;
  localparam logic [3:0] LHU = 4'b0101;
  localparam logic [3:0] SB  = 4'b1001;
  localparam logic [3:0] SH  = 4'b1010;
  localparam logic [3:0] SW  = 4'b1011;

  typedef struct packed {
    logic [31:0] res;
    logic        mis;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  lsu_if #(.CPU_WIDTH(32)) bus ();
  lsu #(.CPU_WIDTH(32)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.i_pre_valid  = 1'b0;
    bus.i_exu_res    = '0;
    bus.i_rs2        = '0;
    bus.i_lsu_opt    = NOP;
    bus.i_post_ready = 1'b1;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
  endtask

  // Offer an op at the current negedge, queue its expectation, return after the accepting edge.
  task automatic send(input logic [3:0] opt, input logic [31:0] addr, input logic [31:0] rs2,
                      input exp_t e);
    bus.i_pre_valid = 1'b1;
    bus.i_lsu_opt   = opt;
    bus.i_exu_res   = addr;
    bus.i_rs2       = rs2;
    sb.push_back(e);
    @(negedge clk);
    bus.i_pre_valid = 1'b0;
  endtask

  function automatic logic [31:0] model_load(logic [3:0] opt, logic [1:0] lane, logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> (8 * lane);
    case (opt)
      LB:      return 32'($signed(s[7:0]));
      LH:      return 32'($signed(s[15:0]));
      LW:      return rdata;
      LBU:     return {24'h0, s[7:0]};
      LHU:     return {16'h0, s[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.o_pre_ready, bus.o_post_valid, bus.o_mem_valid, bus.o_mem_wen, bus.o_mem_addr,
         bus.o_mem_wdata, bus.o_mem_wmask, bus.o_lsu_res, bus.o_misalign} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: pre_rdy=%b post_v=%b mem_v=%b wen=%b addr=%h wdata=%h wmask=%b res=%h mis=%b want 1 0 0 0 0 0 0 0 0",
               bus.o_pre_ready, bus.o_post_valid, bus.o_mem_valid, bus.o_mem_wen, bus.o_mem_addr,
               bus.o_mem_wdata, bus.o_mem_wmask, bus.o_lsu_res, bus.o_misalign);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nop();
    exp_t e;
    e = '{res: 32'h1234_5678, mis: 1'b0};
    bus.i_post_ready = 1'b1;
    send(NOP, 32'h1234_5678, 32'h0, e);
    e = sb.pop_front();
    n_vec++;
    if ({bus.o_post_valid, bus.o_mem_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b1, 1'b0, e.res, e.mis}) begin
      n_err++;
      $display("FAIL nop_resp: post_v=%b mem_v=%b res=%h mis=%b want 1 0 %h %b",
               bus.o_post_valid, bus.o_mem_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
    end
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e = '{res: (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080, mis: 1'b0};
      send((k == 0) ? LB : LBU, 32'h8000_0003, 32'h0, e);
      n_vec++;
      if ({bus.o_mem_valid, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 4'b0000}) begin
        n_err++;
        $display("FAIL lb_req[%0d]: mem_v=%b wen=%b addr=%h wmask=%b want 1 0 80000000 0000",
                 k, bus.o_mem_valid, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wmask);
      end
      bus.i_mem_ready = 1'b1;
      @(negedge clk);
      bus.i_mem_ready  = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = 32'h80FF_0000;
      @(negedge clk);
      bus.i_mem_rvalid = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if ({bus.o_post_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b1, e.res, e.mis}) begin
        n_err++;
        $display("FAIL lb_resp[%0d]: post_v=%b res=%h mis=%b want 1 %h %b",
                 k, bus.o_post_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_stall();
    exp_t e;
    e = '{res: 32'h0, mis: 1'b0};
    send(SH, 32'h8000_0002, 32'hAAAA_BEEF, e);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({bus.o_mem_valid, bus.o_post_valid, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_wmask} !==
          {1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100}) begin
        n_err++;
        $display("FAIL sh_stall[%0d]: mem_v=%b post_v=%b wen=%b addr=%h wdata=%h wmask=%b want 1 0 1 80000000 beefbeef 1100",
                 i, bus.o_mem_valid, bus.o_post_valid, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_wmask);
      end
      @(negedge clk);
    end
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_ready  = 1'b1;
    @(negedge clk);
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if ({bus.o_post_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b1, e.res, e.mis}) begin
      n_err++;
      $display("FAIL sh_resp: post_v=%b res=%h mis=%b want 1 %h %b",
               bus.o_post_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    logic [3:0]  ops[5]   = '{LW, LH, SW, LHU, SH};
    logic [31:0] addrs[5] = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0002, 32'h0000_0001, 32'h0000_0005};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e = '{res: 32'h0, mis: 1'b1};
      send(ops[i], addrs[i], 32'hFFFF_FFFF, e);
      e = sb.pop_front();
      n_vec++;
      if ({bus.o_mem_valid, bus.o_post_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b0, 1'b1, e.res, e.mis}) begin
        n_err++;
        $display("FAIL misalign[%0d]: mem_v=%b post_v=%b res=%h mis=%b want 0 1 %h %b",
                 i, bus.o_mem_valid, bus.o_post_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lanes();
    logic [3:0]  ops[8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    logic [3:0]  opt;
    logic [1:0]  lane;
    logic [31:0] r, addr, rs2, rdata, ewdata;
    logic [3:0]  ewmask;
    logic        ewen;
    exp_t        e;
    int          w;
    for (int it = 0; it < 16; it++) begin
      opt   = ops[$urandom_range(0, 7)];
      r     = $urandom();
      rs2   = $urandom();
      rdata = $urandom();
      case (opt)
        LW, SW:      lane = 2'd0;
        LH, LHU, SH: lane = 2'($urandom_range(0, 1) * 2);
        default:     lane = 2'($urandom_range(0, 3));
      endcase
      addr   = {r[31:2], lane};
      ewen   = opt[3];
      ewdata = 32'h0;
      ewmask = 4'b0000;
      case (opt)
        SB: begin ewdata = {4{rs2[7:0]}};  ewmask = 4'b0001 << lane; end
        SH: begin ewdata = {2{rs2[15:0]}}; ewmask = 4'b0011 << lane; end
        SW: begin ewdata = rs2;            ewmask = 4'b1111;         end
        default: ;
      endcase
      e = '{res: model_load(opt, lane, rdata), mis: 1'b0};
      send(opt, addr, rs2, e);
      n_vec++;
      if ({bus.o_mem_valid, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_wmask} !==
          {1'b1, ewen, {addr[31:2], 2'b00}, ewdata, ewmask}) begin
        n_err++;
        $display("FAIL lane_req[%0d] op=%b: mem_v=%b wen=%b addr=%h wdata=%h wmask=%b want 1 %b %h %h %b",
                 it, opt, bus.o_mem_valid, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_mem_wmask,
                 ewen, {addr[31:2], 2'b00}, ewdata, ewmask);
      end
      bus.i_mem_ready = 1'b1;
      @(negedge clk);
      bus.i_mem_ready  = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      bus.i_mem_rdata  = rdata;
      @(negedge clk);
      bus.i_mem_rvalid = 1'b0;
      w = 0;
      while (!bus.o_post_valid && w < 4) begin
        @(negedge clk);
        w++;
      end
      e = sb.pop_front();
      n_vec++;
      if ({bus.o_post_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b1, e.res, e.mis}) begin
        n_err++;
        $display("FAIL lane_resp[%0d] op=%b lane=%0d: post_v=%b res=%h mis=%b want 1 %h %b",
                 it, opt, lane, bus.o_post_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus.i_post_ready = 1'b0;
    e = '{res: 32'hCAFE_F00D, mis: 1'b0};
    send(NOP, 32'hCAFE_F00D, 32'h0, e);
    bus.i_pre_valid = 1'b1;
    bus.i_lsu_opt   = NOP;
    bus.i_exu_res   = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({bus.o_post_valid, bus.o_pre_ready, bus.o_lsu_res, bus.o_misalign} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: post_v=%b pre_rdy=%b res=%h mis=%b want 1 0 cafef00d 0",
                 i, bus.o_post_valid, bus.o_pre_ready, bus.o_lsu_res, bus.o_misalign);
      end
      @(negedge clk);
    end
    bus.i_post_ready = 1'b1;
    e = sb.pop_front();
    n_vec++;
    if ({bus.o_post_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b1, e.res, e.mis}) begin
      n_err++;
      $display("FAIL bp_resp1: post_v=%b res=%h mis=%b want 1 %h %b",
               bus.o_post_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.o_pre_ready, bus.o_post_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_idle_gap: pre_rdy=%b post_v=%b want 1 0", bus.o_pre_ready, bus.o_post_valid);
    end
    sb.push_back('{res: 32'h1111_1111, mis: 1'b0});
    @(negedge clk);
    bus.i_pre_valid = 1'b0;
    e = sb.pop_front();
    n_vec++;
    if ({bus.o_post_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b1, e.res, e.mis}) begin
      n_err++;
      $display("FAIL bp_resp2: post_v=%b res=%h mis=%b want 1 %h %b",
               bus.o_post_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    exp_t e;
    e = '{res: 32'h0, mis: 1'b0};
    send(LW, 32'h8000_0010, 32'h0, e);
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    bus.i_mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_vec++;
    if ({bus.o_mem_valid, bus.o_post_valid, bus.o_pre_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL rst_in_wait: mem_v=%b post_v=%b pre_rdy=%b want 0 0 1",
               bus.o_mem_valid, bus.o_post_valid, bus.o_pre_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.i_mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({bus.o_mem_valid, bus.o_post_valid, bus.o_pre_ready} !== 3'b001) begin
        n_err++;
        $display("FAIL late_rvalid[%0d]: mem_v=%b post_v=%b pre_rdy=%b want 0 0 1",
                 i, bus.o_mem_valid, bus.o_post_valid, bus.o_pre_ready);
      end
      @(negedge clk);
    end
    e = '{res: 32'h0BAD_F00D, mis: 1'b0};
    send(NOP, 32'h0BAD_F00D, 32'h0, e);
    e = sb.pop_front();
    n_vec++;
    if ({bus.o_post_valid, bus.o_lsu_res, bus.o_misalign} !== {1'b1, e.res, e.mis}) begin
      n_err++;
      $display("FAIL post_rst_nop: post_v=%b res=%h mis=%b want 1 %h %b",
               bus.o_post_valid, bus.o_lsu_res, bus.o_misalign, e.res, e.mis);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nop();
    test_load_byte();
    test_store_stall();
    test_misalign();
    test_lanes();
    test_back_to_back();
    test_reset_in_wait();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
